// File: rtl/pixel_readout_pkg.sv
// Shared types for the pixel array readout sequencer.
// Holds the FSM state encoding and the pixel index width helper.
package pixel_readout_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_GAP,
        S_SETTLE,
        S_CAPTURE,
        S_OUT
    } state_t;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pixel_array_readout.sv
// Readout sequencer for an N-pixel array on one shared DATA bus.
// Ports: clk/reset, start/continuous/exposure control, erase/expose/
// convert strobes, counter bus drive, one-hot read select, data_i,
// valid/ready sample stream (data, idx, last), busy and frame_done.
import pixel_readout_pkg::*;

module pixel_array_readout #(
    parameter int NUM_PIXELS   = 4,
    parameter int DATA_W       = 8,
    parameter int ERASE_CYCLES = 5,
    parameter int EXP_W        = 16,
    parameter int IDX_W        = idx_width(NUM_PIXELS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  continuous_i,
    input  logic [EXP_W-1:0]      expose_cycles_i,
    output logic                  erase_o,
    output logic                  expose_o,
    output logic                  convert_o,
    output logic [DATA_W-1:0]     cnt_o,
    output logic                  cnt_oe_o,
    output logic [NUM_PIXELS-1:0] read_o,
    input  logic [DATA_W-1:0]     data_i,
    output logic                  px_valid_o,
    input  logic                  px_ready_i,
    output logic [DATA_W-1:0]     px_data_o,
    output logic [IDX_W-1:0]      px_idx_o,
    output logic                  px_last_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    // One counter serves erase/expose (down) and conversion (up).
    localparam int EW  = $clog2(ERASE_CYCLES + 1);
    localparam int CW0 = (EXP_W > DATA_W) ? EXP_W : DATA_W;
    localparam int CW  = (CW0 > EW) ? CW0 : EW;

    localparam logic [CW-1:0]         ONE     = 1;
    localparam logic [CW-1:0]         ERASE_N = CW'(ERASE_CYCLES - 1);
    localparam logic [DATA_W-1:0]     CNT_MAX = '1;
    localparam logic [IDX_W-1:0]      LAST_K  = IDX_W'(NUM_PIXELS - 1);
    localparam logic [IDX_W-1:0]      K_ONE   = 1;
    localparam logic [NUM_PIXELS-1:0] SEL0    = 1;
    localparam logic [EXP_W-1:0]      EXP_ONE = 1;

    state_t            state, nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [IDX_W-1:0]  k, k_nxt;
    logic [EXP_W-1:0]  exp_len, exp_nxt;
    logic              done_nxt;
    logic [EXP_W-1:0]  exp_in;

    // A zero exposure request still exposes for one cycle.
    assign exp_in = (expose_cycles_i == '0) ? EXP_ONE : expose_cycles_i;

    always_comb begin
        nxt      = state;
        cnt_nxt  = cnt;
        k_nxt    = k;
        exp_nxt  = exp_len;
        done_nxt = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_i) begin
                    nxt     = S_ERASE;
                    cnt_nxt = ERASE_N;
                    exp_nxt = exp_in;
                end
            end
            S_ERASE: begin
                if (cnt == '0) begin
                    nxt     = S_EXPOSE;
                    cnt_nxt = CW'(exp_len) - ONE;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            S_EXPOSE: begin
                if (cnt == '0) begin
                    nxt     = S_CONVERT;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            S_CONVERT: begin
                if (cnt[DATA_W-1:0] == CNT_MAX) begin
                    nxt     = S_GAP;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            S_GAP: begin
                nxt   = S_SETTLE;
                k_nxt = '0;
            end
            S_SETTLE:  nxt = S_CAPTURE;
            S_CAPTURE: nxt = S_OUT;
            S_OUT: begin
                if (px_ready_i) begin
                    if (k == LAST_K) begin
                        done_nxt = 1'b1;
                        if (continuous_i) begin
                            nxt     = S_ERASE;
                            cnt_nxt = ERASE_N;
                            exp_nxt = exp_in;
                        end else begin
                            nxt = S_IDLE;
                        end
                    end else begin
                        k_nxt = k + K_ONE;
                        nxt   = S_SETTLE;
                    end
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so every
    // strobe lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            k            <= '0;
            exp_len      <= '0;
            erase_o      <= 1'b0;
            expose_o     <= 1'b0;
            convert_o    <= 1'b0;
            cnt_o        <= '0;
            cnt_oe_o     <= 1'b0;
            read_o       <= '0;
            px_valid_o   <= 1'b0;
            px_data_o    <= '0;
            px_idx_o     <= '0;
            px_last_o    <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            state        <= nxt;
            cnt          <= cnt_nxt;
            k            <= k_nxt;
            exp_len      <= exp_nxt;
            erase_o      <= (nxt == S_ERASE);
            expose_o     <= (nxt == S_EXPOSE);
            convert_o    <= (nxt == S_CONVERT);
            cnt_oe_o     <= (nxt == S_CONVERT);
            cnt_o        <= (nxt == S_CONVERT) ? cnt_nxt[DATA_W-1:0] : '0;
            read_o       <= (nxt == S_SETTLE || nxt == S_CAPTURE) ?
                            (SEL0 << k_nxt) : '0;
            px_valid_o   <= (nxt == S_OUT);
            busy_o       <= (nxt != S_IDLE);
            frame_done_o <= done_nxt;
            if (state == S_CAPTURE) begin
                px_data_o <= data_i;
                px_idx_o  <= k;
                px_last_o <= (k == LAST_K);
            end
        end
    end

endmodule

// File: tb/tb_pixel_array_readout.sv
// Scoreboard bench for pixel_array_readout (4x8 and 1x4 instances).
// Directed frames: basic, backpressure, zero exposure, continuous, reset.
module tb_pixel_array_readout;

    logic       clk = 0;
    logic       reset = 0;
    always #5 clk = ~clk;

    logic        start = 0, cont = 0, ready = 1;
    logic [15:0] expose = 16'd10;
    logic        erase_o, expose_o, convert_o, cnt_oe_o;
    logic [7:0]  cnt_o, data_i, px_data_o, base = 8'h10;
    logic [3:0]  read_o;
    logic        px_valid_o, px_last_o, busy_o, frame_done_o;
    logic [1:0]  px_idx_o;

    pixel_array_readout #(
        .NUM_PIXELS(4), .DATA_W(8), .ERASE_CYCLES(5), .EXP_W(16)
    ) u0 (
        .clk(clk), .reset(reset), .start_i(start), .continuous_i(cont),
        .expose_cycles_i(expose), .erase_o(erase_o), .expose_o(expose_o),
        .convert_o(convert_o), .cnt_o(cnt_o), .cnt_oe_o(cnt_oe_o),
        .read_o(read_o), .data_i(data_i), .px_valid_o(px_valid_o),
        .px_ready_i(ready), .px_data_o(px_data_o), .px_idx_o(px_idx_o),
        .px_last_o(px_last_o), .busy_o(busy_o), .frame_done_o(frame_done_o)
    );

    logic        start1 = 0, cont1 = 0, ready1 = 1;
    logic [15:0] expose1 = 16'd3;
    logic        erase1, expose1_o, convert1, cnt_oe1;
    logic [3:0]  cnt1, data1, pxd1;
    logic [0:0]  read1, pxi1;
    logic        pxv1, pxl1, busy1, done1;

    pixel_array_readout #(
        .NUM_PIXELS(1), .DATA_W(4), .ERASE_CYCLES(2), .EXP_W(16)
    ) u1 (
        .clk(clk), .reset(reset), .start_i(start1), .continuous_i(cont1),
        .expose_cycles_i(expose1), .erase_o(erase1), .expose_o(expose1_o),
        .convert_o(convert1), .cnt_o(cnt1), .cnt_oe_o(cnt_oe1),
        .read_o(read1), .data_i(data1), .px_valid_o(pxv1),
        .px_ready_i(ready1), .px_data_o(pxd1), .px_idx_o(pxi1),
        .px_last_o(pxl1), .busy_o(busy1), .frame_done_o(done1)
    );

    // Pixel model: selected pixel k drives base+k onto the bus.
    always_comb begin
        data_i = 8'h00;
        for (int i = 0; i < 4; i++)
            if (read_o[i]) data_i = base + 8'(i);
    end
    assign data1 = read1[0] ? 4'h9 : 4'h0;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] i;
        logic       l;
    } smp_t;
    smp_t sb[$];

    int errors = 0, checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor state for u0
    int cyc, n_er, n_ex, n_cv, stall;
    int r_len, r_er, r_ex, r_cv, r_stall, done_cnt = 0;
    int ovl = 0, cnt_err = 0, stall_err = 0;
    logic erase_at_done = 0, prev_valid = 0, prev_hs = 0;
    logic [7:0] prev_d;
    logic [1:0] prev_i;
    logic       prev_l;
    smp_t       e;

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            cyc = 0; n_er = 0; n_ex = 0; n_cv = 0; stall = 0;
            prev_valid = 0; prev_hs = 0;
        end else begin
            if (read_o != 4'b0 && cnt_oe_o) ovl++;
            if (!$onehot0(read_o)) ovl++;
            if (convert_o != cnt_oe_o) ovl++;
            if (frame_done_o) begin
                done_cnt++;
                r_len = cyc; r_er = n_er; r_ex = n_ex;
                r_cv = n_cv; r_stall = stall;
                erase_at_done = erase_o;
                cyc = 0; n_er = 0; n_ex = 0; n_cv = 0; stall = 0;
            end
            if (busy_o) cyc++;
            if (erase_o) n_er++;
            if (expose_o) n_ex++;
            if (cnt_oe_o) begin
                if (cnt_o != 8'(n_cv)) cnt_err++;
                n_cv++;
            end
            if (px_valid_o) begin
                if (read_o != 4'b0) stall_err++;
                if (prev_valid && !prev_hs &&
                    (px_data_o != prev_d || px_idx_o != prev_i ||
                     px_last_o != prev_l)) stall_err++;
                if (!ready) stall++;
                else if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sample_unexpected: got idx %0d expected none",
                             px_idx_o);
                end else begin
                    e = sb.pop_front();
                    chk("sample_data", px_data_o, e.d);
                    chk("sample_idx", px_idx_o, e.i);
                    chk("sample_last", px_last_o, e.l);
                end
            end
            prev_valid = px_valid_o;
            prev_hs = px_valid_o && ready;
            prev_d = px_data_o; prev_i = px_idx_o; prev_l = px_last_o;
        end
    end

    // Monitor state for u1
    int cv1, len1, r_len1, r_cv1, ovl1 = 0, s1_n = 0;
    logic [3:0] s1_d;
    logic       s1_l;
    logic [0:0] s1_i;

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            cv1 = 0; len1 = 0;
        end else begin
            if (read1 != 1'b0 && cnt_oe1) ovl1++;
            if (done1) begin
                r_len1 = len1; r_cv1 = cv1; len1 = 0; cv1 = 0;
            end
            if (busy1) len1++;
            if (cnt_oe1) begin
                if (cnt1 != 4'(cv1)) ovl1++;
                cv1++;
            end
            if (pxv1 && ready1) begin
                s1_n++; s1_d = pxd1; s1_l = pxl1; s1_i = pxi1;
            end
        end
    end

    task automatic push_frame(input logic [7:0] b);
        for (int k = 0; k < 4; k++)
            sb.push_back({b + 8'(k), 2'(k), (k == 3)});
    endtask

    task automatic run_start(input int ex, input logic c);
        expose = 16'(ex); cont = c; start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        do begin
            @(posedge clk); #6;
            n++;
        end while (!frame_done_o && n < 3000);
        chk({nm, "_done_seen"}, frame_done_o, 1);
    endtask

    task automatic check_frame(input string nm, input int ex,
                               input int st, input int left);
        chk({nm, "_erase"}, r_er, 5);
        chk({nm, "_expose"}, r_ex, ex);
        chk({nm, "_convert"}, r_cv, 256);
        chk({nm, "_stall"}, r_stall, st);
        chk({nm, "_length"}, r_len, 5 + ex + 256 + 1 + 12 + st);
        chk({nm, "_sb_left"}, sb.size(), left);
        chk({nm, "_cnt_seq"}, cnt_err, 0);
    endtask

    initial begin
        int n, d0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {erase_o, expose_o, convert_o, cnt_o,
            cnt_oe_o, read_o, px_valid_o, px_data_o, px_idx_o,
            px_last_o, busy_o, frame_done_o}, 0);
        reset = 1;
        repeat (2) @(posedge clk); #1;
        chk("idle_busy", busy_o, 0);

        // Basic frame
        base = 8'h10; push_frame(8'h10);
        run_start(10, 0);
        chk("erase_after_start", erase_o, 1);
        wait_done("basic");
        check_frame("basic", 10, 0, 0);
        chk("basic_idle", busy_o, 0);

        // Backpressure at idx 1, plus an ignored start mid-frame
        base = 8'h40; push_frame(8'h40);
        run_start(10, 0);
        repeat (20) @(posedge clk);
        #1 start = 1;
        @(posedge clk); #1 start = 0;
        n = 0;
        while (read_o != 4'b0010 && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        chk("bp_reach_idx1", read_o, 4'b0010);
        ready = 0;
        repeat (2) @(posedge clk); #1;
        chk("bp_valid", px_valid_o, 1);
        chk("bp_idx", px_idx_o, 1);
        repeat (7) @(posedge clk); #1;
        ready = 1;
        wait_done("bp");
        check_frame("bp", 10, 7, 0);
        chk("bp_stable", stall_err, 0);

        // Zero exposure, request changed mid-frame
        base = 8'h10; push_frame(8'h10);
        run_start(0, 0);
        repeat (3) @(posedge clk); #1;
        expose = 16'd9;
        wait_done("exp0");
        check_frame("exp0", 1, 0, 0);

        // Continuous: two frames, drop continuous during frame 2
        base = 8'h22; push_frame(8'h22); push_frame(8'h22);
        run_start(4, 1);
        wait_done("cont1");
        chk("cont1_erase_at_done", erase_at_done, 1);
        chk("cont1_busy", busy_o, 1);
        check_frame("cont1", 4, 0, 4);
        cont = 0;
        wait_done("cont2");
        chk("cont2_erase_at_done", erase_at_done, 0);
        check_frame("cont2", 4, 0, 0);
        repeat (10) @(posedge clk); #1;
        chk("cont2_idle", busy_o, 0);

        // Reset during CONVERT
        d0 = done_cnt;
        run_start(10, 0);
        n = 0;
        while (!convert_o && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("rst1_in_convert", convert_o, 1);
        reset = 0;
        @(posedge clk); #1;
        chk("rst1_outputs", {erase_o, expose_o, convert_o, cnt_o,
            cnt_oe_o, read_o, px_valid_o, px_data_o, px_idx_o,
            px_last_o, busy_o, frame_done_o}, 0);
        reset = 1;
        repeat (300) @(posedge clk); #1;
        chk("rst1_no_done", done_cnt, d0);
        chk("rst1_idle", busy_o, 0);

        // Reset during OUT
        ready = 0;
        run_start(2, 0);
        n = 0;
        while (!px_valid_o && n < 400) begin
            @(posedge clk); #1; n++;
        end
        chk("rst2_in_out", px_valid_o, 1);
        reset = 0;
        @(posedge clk); #1;
        chk("rst2_outputs", {erase_o, expose_o, convert_o, cnt_o,
            cnt_oe_o, read_o, px_valid_o, px_data_o, px_idx_o,
            px_last_o, busy_o, frame_done_o}, 0);
        reset = 1; ready = 1;
        repeat (20) @(posedge clk); #1;
        chk("rst2_no_done", done_cnt, d0);

        // Normal frame after resets
        base = 8'h55; push_frame(8'h55);
        run_start(2, 0);
        wait_done("post_rst");
        check_frame("post_rst", 2, 0, 0);
        chk("no_overlap", ovl, 0);

        // Single-pixel, 4-bit instance
        start1 = 1;
        @(posedge clk); #1 start1 = 0;
        n = 0;
        do begin
            @(posedge clk); #6; n++;
        end while (!done1 && n < 200);
        chk("p1_done_seen", done1, 1);
        chk("p1_convert", r_cv1, 16);
        chk("p1_length", r_len1, 2 + 3 + 16 + 1 + 3);
        chk("p1_samples", s1_n, 1);
        chk("p1_data", s1_d, 9);
        chk("p1_idx", s1_i, 0);
        chk("p1_last", s1_l, 1);
        chk("p1_no_overlap", ovl1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
